edge_hysteresis_link: RTL and testbench

Parametrised hysteresis edge-linking stage for the Canny pipeline: consumes the raster stream of per-pixel strength classes from non-maximum suppression/double-threshold, builds its own 3x3 neighbourhood with internal line buffers, and emits a binary edge-map pixel stream toward the VGA/frame-buffer writer. It supersedes the fixed three-row linker. It adds frame framing, explicit image-border handling, an end-of-frame flush, and configurable output levels and image geometry.

---
 rtl/edge_pkg.sv | 23 ++
 rtl/edge_line_buf.sv | 28 ++
 rtl/edge_hysteresis_link.sv | 158 +++++++++++++++
 tb/tb_edge_hysteresis_link.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// edge_pkg: shared class encoding, FSM states and statistics width for the hysteresis edge linker
package edge_pkg;

    localparam int CLS_WEAK   = 0;
    localparam int CLS_STRONG = 1;
    localparam int CNT_W      = 20;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    function automatic logic is_strong(input logic [1:0] cls);
        return cls[CLS_STRONG];
    endfunction

    function automatic logic is_weak(input logic [1:0] cls);
        return cls[CLS_WEAK] & ~cls[CLS_STRONG];
    endfunction

    // a window column packs rows {r-2, r-1, r} as {[5:4], [3:2], [1:0]}
    function automatic logic col_strong(input logic [5:0] col);
        return is_strong(col[5:4]) | is_strong(col[3:2]) | is_strong(col[1:0]);
    endfunction

endpackage

// File: rtl/edge_line_buf.sv
// edge_line_buf: two-line delay of 2-bit classes, returns the previous two rows at the addressed column
module edge_line_buf #(
    parameter int IMG_W = 640,
    parameter int AW    = $clog2(IMG_W)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [1:0]    din,
    output logic [1:0]    row1,
    output logic [1:0]    row2
);

    logic [1:0] l1_q [IMG_W];
    logic [1:0] l2_q [IMG_W];

    // each write pushes the column's history down one row; stale contents are masked by the reader
    always_ff @(posedge clk) begin
        if (we) begin
            l1_q[addr] <= din;
            l2_q[addr] <= l1_q[addr];
        end
    end

    assign row1 = l1_q[addr];
    assign row2 = l2_q[addr];

endmodule

// File: rtl/edge_hysteresis_link.sv
// edge_hysteresis_link: single-pass hysteresis edge linking over a raster stream of pixel classes.
// Optional per-frame strong/linked statistics are built when HYST_STATS_EN is defined.
module edge_hysteresis_link
    import edge_pkg::*;
#(
    parameter int               IMG_W    = 640,
    parameter int               IMG_H    = 480,
    parameter int               OUT_W    = 8,
    parameter logic [OUT_W-1:0] EDGE_VAL = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [1:0]       in_class,
    output logic             out_valid,
    output logic             out_sof,
    output logic             out_eol,
    output logic [OUT_W-1:0] out_pix,
    output logic             stats_valid,
    output logic [CNT_W-1:0] strong_cnt,
    output logic [CNT_W-1:0] linked_cnt
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H + 2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_END  = RW'(IMG_H + 1);

    state_t           state_q, state_d;
    logic [RW-1:0]    row_q, row_d, pos_row;
    logic [CW-1:0]    col_q, col_d, pos_col;
    logic             sof, flushing, beat, emit;
    logic [1:0]       r1, r2, ctr;
    logic [5:0]       new_col, left_col, right_col;
    logic [5:0]       w0_q, w0_d, w1_q, w1_d;
    logic             nbr_strong, edge_hit;
    logic             out_valid_q, out_valid_d, out_sof_q, out_sof_d, out_eol_q, out_eol_d;
    logic [OUT_W-1:0] out_pix_q, out_pix_d;

    edge_line_buf #(.IMG_W(IMG_W), .AW(CW)) u_line_buf (
        .clk  (clk),
        .we   (beat),
        .addr (pos_col),
        .din  (new_col[1:0]),
        .row1 (r1),
        .row2 (r2)
    );

    // beat sequencing: a beat writes (pos_row,pos_col) and evaluates the centre W+1 pixels behind it
    always_comb begin
        sof       = in_valid & in_sof;
        flushing  = (state_q == FLUSH) & ~sof;
        beat      = sof | ((state_q == RUN) & in_valid) | (state_q == FLUSH);
        pos_row   = sof ? '0 : row_q;
        pos_col   = sof ? '0 : col_q;
        col_d     = beat ? ((pos_col == COL_LAST) ? '0 : pos_col + 1'b1) : col_q;
        row_d     = beat ? ((pos_col == COL_LAST) ? pos_row + 1'b1 : pos_row) : row_q;
        state_d   = sof ? RUN
                  : ((state_q == RUN) && in_valid && pos_row == ROW_LAST && pos_col == COL_LAST) ? FLUSH
                  : (flushing && pos_row == ROW_END) ? IDLE
                  : state_q;
        new_col   = {(pos_row < RW'(2)) ? 2'b00 : r2,
                     (pos_row == '0) ? 2'b00 : r1,
                     flushing ? 2'b00 : in_class};
        left_col  = (pos_col == CW'(1)) ? '0 : w0_q;
        right_col = (pos_col == '0) ? '0 : new_col;
        ctr       = w1_q[3:2];
        nbr_strong = col_strong(left_col) | col_strong(right_col) | is_strong(w1_q[5:4]) | is_strong(w1_q[1:0]);
        edge_hit  = is_strong(ctr) | (is_weak(ctr) & nbr_strong);
        emit      = beat & ((pos_row >= RW'(2)) | ((pos_row == RW'(1)) & (pos_col != '0)));
        w1_d      = beat ? new_col : w1_q;
        w0_d      = beat ? w1_q : w0_q;
        out_valid_d = emit;
        out_sof_d = emit & (pos_row == RW'(1)) & (pos_col == CW'(1));
        out_eol_d = emit & (pos_col == '0);
        out_pix_d = (emit & edge_hit) ? EDGE_VAL : '0;
    end

    // FSM, raster position, window and registered output pixel
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            w0_q        <= '0;
            w1_q        <= '0;
            out_valid_q <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_pix_q   <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
            out_valid_q <= out_valid_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            out_pix_q   <= out_pix_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;
    assign out_pix   = out_pix_q;

`ifdef HYST_STATS_EN
    logic [CNT_W-1:0] strong_acc_q, strong_acc_d, linked_acc_q, linked_acc_d;
    logic [CNT_W-1:0] strong_cnt_q, strong_cnt_d, linked_cnt_q, linked_cnt_d;
    logic             last_q, last_d, stats_valid_q, stats_valid_d;

    // saturating per-frame accumulators, latched one clk after the frame's final output
    always_comb begin
        strong_acc_d  = sof ? '0
                      : (emit & is_strong(ctr) & ~&strong_acc_q) ? strong_acc_q + 1'b1
                      : strong_acc_q;
        linked_acc_d  = sof ? '0
                      : (emit & is_weak(ctr) & nbr_strong & ~&linked_acc_q) ? linked_acc_q + 1'b1
                      : linked_acc_q;
        last_d        = flushing & (pos_row == ROW_END);
        stats_valid_d = last_q;
        strong_cnt_d  = last_q ? strong_acc_q : strong_cnt_q;
        linked_cnt_d  = last_q ? linked_acc_q : linked_cnt_q;
    end

    // statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            strong_acc_q  <= '0;
            linked_acc_q  <= '0;
            strong_cnt_q  <= '0;
            linked_cnt_q  <= '0;
            last_q        <= 1'b0;
            stats_valid_q <= 1'b0;
        end else begin
            strong_acc_q  <= strong_acc_d;
            linked_acc_q  <= linked_acc_d;
            strong_cnt_q  <= strong_cnt_d;
            linked_cnt_q  <= linked_cnt_d;
            last_q        <= last_d;
            stats_valid_q <= stats_valid_d;
        end
    end

    assign stats_valid = stats_valid_q;
    assign strong_cnt  = strong_cnt_q;
    assign linked_cnt  = linked_cnt_q;
`else
    assign stats_valid = 1'b0;
    assign strong_cnt  = '0;
    assign linked_cnt  = '0;
`endif

endmodule

// File: tb/tb_edge_hysteresis_link.sv
// tb_edge_hysteresis_link: scoreboard bench for the hysteresis edge linker on an 8x4 image
module tb_edge_hysteresis_link;

    localparam int W = 8;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [1:0]  in_class = 2'b00;
    logic        out_valid, out_sof, out_eol, stats_valid;
    logic [7:0]  out_pix;
    logic [19:0] strong_cnt, linked_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  img [H][W];
    logic [9:0]  exp_q [$];
    int          sv_seen = 0;
    logic [19:0] sv_strong = '0;
    logic [19:0] sv_linked = '0;
    int          exp_strong = 0;
    int          exp_linked = 0;

    edge_hysteresis_link #(.IMG_W(W), .IMG_H(H), .OUT_W(8), .EDGE_VAL(8'hFF)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_class    (in_class),
        .out_valid   (out_valid),
        .out_sof     (out_sof),
        .out_eol     (out_eol),
        .out_pix     (out_pix),
        .stats_valid (stats_valid),
        .strong_cnt  (strong_cnt),
        .linked_cnt  (linked_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    function automatic logic [1:0] cls_at(input int r, input int c);
        if (r < 0 || r >= H || c < 0 || c >= W) return 2'b00;
        return img[r][c];
    endfunction

    // one clock: inputs applied before the edge, outputs sampled at the following falling edge
    task automatic tick();
        logic [9:0] e;
        @(posedge clk);
        @(negedge clk);
        if (stats_valid) begin
            sv_seen++;
            sv_strong = strong_cnt;
            sv_linked = linked_cnt;
        end
        if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got out_valid=1 pix=%h sof=%b eol=%b, expected no output", out_pix, out_sof, out_eol);
            end else begin
                e = exp_q.pop_front();
                if ({out_sof, out_eol, out_pix} !== e) begin
                    errors++;
                    $display("FAIL pixel: got sof=%b eol=%b pix=%h, expected sof=%b eol=%b pix=%h",
                             out_sof, out_eol, out_pix, e[9], e[8], e[7:0]);
                end
            end
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [1:0] c);
        in_valid = v;
        in_sof   = s;
        in_class = c;
        tick();
    endtask

    task automatic clear_img();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) img[r][c] = 2'b00;
    endtask

    task automatic rand_img();
        int v;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                v = int'($urandom_range(0, 9));
                img[r][c] = (v < 2) ? 2'b10 : (v < 5) ? 2'b01 : (v == 9) ? 2'b11 : 2'b00;
            end
    endtask

    // reference: expected raster outputs for the current image; first n are queued
    task automatic push_exp(input int n);
        int r, c;
        logic s, w, nb;
        exp_strong = 0;
        exp_linked = 0;
        for (int i = 0; i < W * H; i++) begin
            r  = i / W;
            c  = i % W;
            s  = cls_at(r, c)[1];
            w  = (cls_at(r, c) == 2'b01);
            nb = 1'b0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++)
                    if (dr != 0 || dc != 0) nb = nb | cls_at(r + dr, c + dc)[1];
            if (s) exp_strong++;
            if (w && nb) exp_linked++;
            if (i < n) exp_q.push_back({i == 0, c == W - 1, (s | (w & nb)) ? 8'hFF : 8'h00});
        end
    endtask

    task automatic send(input int n, input bit gaps);
        for (int k = 0; k < n; k++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 2'($urandom_range(0, 3)));
            drive(1'b1, k == 0, img[k / W][k % W]);
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        repeat (4) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d outputs outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({out_valid, out_sof, out_eol} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: got valid/sof/eol=%b, expected 000", {out_valid, out_sof, out_eol});
        end
        checks++;
        if (out_pix !== 8'h00) begin
            errors++;
            $display("FAIL reset_pix: got %h, expected 00", out_pix);
        end
        checks++;
        if ({stats_valid, strong_cnt, linked_cnt} !== 41'd0) begin
            errors++;
            $display("FAIL reset_stats: got sv=%b strong=%0d linked=%0d, expected 0 0 0", stats_valid, strong_cnt, linked_cnt);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_strong();
        clear_img();
        img[1][3] = 2'b10;
        push_exp(W * H);
        send(W * H, 1'b0);
        drain();
    endtask

    task automatic test_link_rules();
        clear_img();
        img[2][4] = 2'b01; img[1][3] = 2'b10;
        img[0][7] = 2'b01; img[1][0] = 2'b10;
        img[3][7] = 2'b01; img[2][6] = 2'b10;
        push_exp(W * H);
        send(W * H, 1'b0);
        drain();
        clear_img();
        img[2][4] = 2'b01; img[0][3] = 2'b10;
        img[0][0] = 2'b11; img[1][1] = 2'b01;
        push_exp(W * H);
        send(W * H, 1'b0);
        drain();
    endtask

    task automatic test_gaps();
        rand_img();
        push_exp(W * H);
        send(W * H, 1'b1);
        drain();
    endtask

    task automatic test_resync();
        rand_img();
        push_exp(4);
        send(13, 1'b0);
        rand_img();
        push_exp(W * H);
        send(W * H, 1'b0);
        drain();
    endtask

    task automatic test_back_to_back();
        rand_img();
        push_exp(W * H - W - 1);
        send(W * H, 1'b0);
        rand_img();
        push_exp(W * H);
        send(W * H, 1'b0);
        drain();
    endtask

    task automatic test_stats();
        clear_img();
        img[0][0] = 2'b10; img[2][2] = 2'b10; img[3][7] = 2'b10;
        img[1][1] = 2'b01; img[3][6] = 2'b01; img[0][5] = 2'b01;
        sv_seen = 0;
        push_exp(W * H);
        send(W * H, 1'b0);
        drain();
`ifdef HYST_STATS_EN
        checks++;
        if (sv_seen != 1) begin
            errors++;
            $display("FAIL stats_pulse: got %0d pulses, expected 1", sv_seen);
        end
        checks++;
        if (sv_strong !== 20'(exp_strong) || sv_linked !== 20'(exp_linked)) begin
            errors++;
            $display("FAIL stats_latch: got strong=%0d linked=%0d, expected %0d %0d", sv_strong, sv_linked, exp_strong, exp_linked);
        end
        checks++;
        if (strong_cnt !== 20'(exp_strong) || linked_cnt !== 20'(exp_linked)) begin
            errors++;
            $display("FAIL stats_hold: got strong=%0d linked=%0d, expected %0d %0d", strong_cnt, linked_cnt, exp_strong, exp_linked);
        end
`else
        checks++;
        if (sv_seen != 0 || strong_cnt !== 20'd0 || linked_cnt !== 20'd0) begin
            errors++;
            $display("FAIL stats_off: got pulses=%0d strong=%0d linked=%0d, expected 0 0 0", sv_seen, strong_cnt, linked_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        rand_img();
        push_exp(11);
        send(20, 1'b0);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got out_valid=%b after reset, expected 0", out_valid);
        end
        rst = 1'b0;
        repeat (12) drive(1'b1, 1'b0, 2'b10);
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_ignore: got out_valid=%b pending=%0d, expected 0 0", out_valid, exp_q.size());
        end
        rand_img();
        push_exp(W * H);
        send(W * H, 1'b0);
        drain();
    endtask

    initial begin
        test_reset();
        test_single_strong();
        test_link_rules();
        test_gaps();
        test_resync();
        test_back_to_back();
        test_stats();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
